// File: rtl/sgm_pkg.sv
// Shared definitions for the SGM stream pipeline stages: default geometry,
// frame-sequencer state encoding and small helpers.
package sgm_pkg;

    // Default image and window geometry shared by the SGM stages.
    localparam int DEF_IMG_W        = 640;
    localparam int DEF_IMG_H        = 480;
    localparam int DEF_WIN_H        = 5;
    localparam int DEF_WIN_W        = 5;
    localparam int DEF_FLUSH_CYCLES = 16;
    localparam int DEF_ROW_WIDTH    = 10;
    localparam int DEF_COL_WIDTH    = 11;
    localparam int DEF_LB_SEL_WIDTH = 2;
    localparam int FRAME_CNT_WIDTH  = 8;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_FLUSH    = 2'd3
    } seq_state_t;

    // Polarity selector for the edge detector.
    typedef enum logic {
        EDGE_RISE = 1'b0,
        EDGE_FALL = 1'b1
    } edge_kind_t;

    // Per-cycle decode of what the sequencer does in the current cycle.
    typedef struct packed {
        logic pixel;      // a counted pixel is accepted
        logic line_end;   // falling de inside ACTIVE
        logic frame_end;  // line_end on the last line of the frame
        logic restart;    // rising vsync inside ACTIVE
        logic sof;        // a frame starts (fresh or restarted)
        logic eof;        // frame completes and drains
        logic err_set;    // any malformed-frame condition
        logic win_valid;  // pixel lies inside the full window area
    } seq_ctrl_t;

    // Increment that wraps back to 0 after reaching 'last'.
    function automatic int wrap_inc(input int value, input int last);
        return (value >= last) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/sgm_frame_sequencer_if.sv
// Video timing in / frame control out bundle of the SGM frame sequencer.
// master = timing source and downstream consumers, slave = the sequencer.
interface sgm_frame_sequencer_if
    import sgm_pkg::*;
#(
    parameter int ROW_WIDTH    = DEF_ROW_WIDTH,
    parameter int COL_WIDTH    = DEF_COL_WIDTH,
    parameter int LB_SEL_WIDTH = DEF_LB_SEL_WIDTH
);

    // Video timing and arm request.
    logic                       de_in;
    logic                       h_sync_in;
    logic                       v_sync_in;
    logic                       enable_in;

    // Pixel stream qualifiers and frame control.
    logic                       de_out;
    logic [ROW_WIDTH-1:0]       row_out;
    logic [COL_WIDTH-1:0]       col_out;
    logic                       win_valid_out;
    logic [LB_SEL_WIDTH-1:0]    lb_wr_sel_out;
    logic                       sof_out;
    logic                       eol_out;
    logic                       eof_out;
    logic                       flush_out;
    logic                       busy_out;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt_out;
    logic                       err_out;

    modport master (
        output de_in, h_sync_in, v_sync_in, enable_in,
        input  de_out, row_out, col_out, win_valid_out, lb_wr_sel_out,
               sof_out, eol_out, eof_out, flush_out, busy_out,
               frame_cnt_out, err_out
    );

    modport slave (
        input  de_in, h_sync_in, v_sync_in, enable_in,
        output de_out, row_out, col_out, win_valid_out, lb_wr_sel_out,
               sof_out, eol_out, eof_out, flush_out, busy_out,
               frame_cnt_out, err_out
    );

endinterface

// File: rtl/sgm_edge_detect.sv
// Registered edge detector: keeps last cycle's level and flags a rising or
// falling transition of the incoming signal in the current cycle.
module sgm_edge_detect
    import sgm_pkg::*;
#(
    parameter edge_kind_t KIND = EDGE_RISE
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic pulse
);

    logic sig_q;

    // Previous-cycle copy of the input level.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values,
        // independent of the order the simulator evaluates blocks in.
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig;
    end

    assign pulse = (KIND == EDGE_RISE) ? (sig & ~sig_q) : (~sig & sig_q);

endmodule

// File: rtl/sgm_frame_sequencer.sv
// Frame-level controller of the SGM pipeline: tracks pixel coordinates,
// arms at frame boundaries, drives line-buffer ping-pong select and the
// window qualifier, drains after the last line and flags malformed frames.
module sgm_frame_sequencer
    import sgm_pkg::*;
#(
    parameter int IMG_W        = DEF_IMG_W,
    parameter int IMG_H        = DEF_IMG_H,
    parameter int WIN_H        = DEF_WIN_H,
    parameter int WIN_W        = DEF_WIN_W,
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int ROW_WIDTH    = DEF_ROW_WIDTH,
    parameter int COL_WIDTH    = DEF_COL_WIDTH,
    parameter int LB_SEL_WIDTH = DEF_LB_SEL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    sgm_frame_sequencer_if.slave bus
);

    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
    localparam int LB_LAST = WIN_H - 2;

    localparam logic [COL_WIDTH-1:0] COL_FULL   = COL_WIDTH'(IMG_W);
    localparam logic [COL_WIDTH-1:0] COL_WIN    = COL_WIDTH'(WIN_W - 1);
    localparam logic [ROW_WIDTH-1:0] ROW_LAST   = ROW_WIDTH'(IMG_H - 1);
    localparam logic [ROW_WIDTH-1:0] ROW_WIN    = ROW_WIDTH'(WIN_H - 1);
    localparam logic [FLUSH_W-1:0]   FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

    seq_state_t                 state;
    seq_state_t                 next_state;
    seq_ctrl_t                  ctrl;

    logic                       de_fall;
    logic                       hs_rise;
    logic                       vs_rise;

    logic [COL_WIDTH-1:0]       col_cnt;
    logic [ROW_WIDTH-1:0]       row_cnt;
    logic [LB_SEL_WIDTH-1:0]    lb_sel;
    logic [FLUSH_W-1:0]         flush_cnt;
    logic                       flush_last;
    logic                       frame_done_q;
    logic [FRAME_CNT_WIDTH-1:0] frame_cnt;
    logic                       err;

    sgm_edge_detect #(.KIND(EDGE_FALL)) u_de_edge (
        .clk   (clk),
        .rst   (rst),
        .sig   (bus.de_in),
        .pulse (de_fall)
    );

    sgm_edge_detect #(.KIND(EDGE_RISE)) u_hs_edge (
        .clk   (clk),
        .rst   (rst),
        .sig   (bus.h_sync_in),
        .pulse (hs_rise)
    );

    sgm_edge_detect #(.KIND(EDGE_RISE)) u_vs_edge (
        .clk   (clk),
        .rst   (rst),
        .sig   (bus.v_sync_in),
        .pulse (vs_rise)
    );

    assign flush_last = (flush_cnt == FLUSH_LAST);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // FSM next-state decode. A rising vsync in ACTIVE re-arms and starts the
    // new frame in the same step, so it stays in ACTIVE; that also covers
    // vsync coinciding with the final line end (vsync wins over FLUSH).
    always_comb begin
        // NOTE: default first so every path assigns next_state; a missing
        // branch would otherwise infer a latch.
        next_state = state;
        unique case (state)
            ST_IDLE:     if (bus.enable_in) next_state = ST_WAIT_SOF;
            ST_WAIT_SOF: if (vs_rise)       next_state = ST_ACTIVE;
            ST_ACTIVE: begin
                if (vs_rise)
                    next_state = ST_ACTIVE;
                else if (de_fall && (row_cnt == ROW_LAST))
                    next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (flush_last)
                    next_state = bus.enable_in ? ST_WAIT_SOF : ST_IDLE;
            end
            default:     next_state = ST_IDLE;
        endcase
    end

    // FSM output decode; everything here is registered before leaving.
    always_comb begin
        ctrl           = '0;
        ctrl.pixel     = (state == ST_ACTIVE) && bus.de_in && (col_cnt < COL_FULL);
        ctrl.line_end  = (state == ST_ACTIVE) && de_fall;
        ctrl.frame_end = ctrl.line_end && (row_cnt == ROW_LAST);
        ctrl.restart   = (state == ST_ACTIVE) && vs_rise;
        ctrl.sof       = ((state == ST_WAIT_SOF) && vs_rise) || ctrl.restart;
        ctrl.eof       = ctrl.frame_end && !ctrl.restart;
        ctrl.win_valid = ctrl.pixel && (row_cnt >= ROW_WIN) && (col_cnt >= COL_WIN);
        // Malformed: wrong line length, pixels past the end of a line,
        // hsync rising mid-line, or vsync cutting the frame short.
        ctrl.err_set   = (ctrl.line_end && (col_cnt != COL_FULL))
                       || ((state == ST_ACTIVE) && bus.de_in && (col_cnt == COL_FULL))
                       || ((state == ST_ACTIVE) && bus.de_in && hs_rise)
                       || (ctrl.restart && !ctrl.frame_end);
    end

    // Coordinate, line-buffer, drain and frame counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt      <= '0;
            row_cnt      <= '0;
            lb_sel       <= '0;
            flush_cnt    <= '0;
            frame_done_q <= 1'b0;
            frame_cnt    <= '0;
            err          <= 1'b0;
        end else begin
            // A restart is applied after the line end, so it overrides it.
            if (ctrl.sof) begin
                col_cnt <= '0;
                row_cnt <= '0;
                lb_sel  <= '0;
            end else if (ctrl.line_end) begin
                col_cnt <= '0;
                if (row_cnt != ROW_LAST) row_cnt <= row_cnt + 1'b1;
                lb_sel  <= LB_SEL_WIDTH'(wrap_inc(int'(lb_sel), LB_LAST));
            end else if (ctrl.pixel) begin
                col_cnt <= col_cnt + 1'b1;
            end

            flush_cnt    <= ((state == ST_FLUSH) && !flush_last) ? flush_cnt + 1'b1 : '0;
            frame_done_q <= (state == ST_FLUSH) && flush_last;
            if (frame_done_q) frame_cnt <= frame_cnt + 1'b1;

            if (ctrl.err_set)  err <= 1'b1;
            else if (ctrl.sof) err <= 1'b0;
        end
    end

    // Registered pixel-stream and frame-control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.de_out        <= 1'b0;
            bus.row_out       <= '0;
            bus.col_out       <= '0;
            bus.win_valid_out <= 1'b0;
            bus.sof_out       <= 1'b0;
            bus.eol_out       <= 1'b0;
            bus.eof_out       <= 1'b0;
            bus.flush_out     <= 1'b0;
            bus.busy_out      <= 1'b0;
        end else begin
            bus.de_out        <= ctrl.pixel;
            if (ctrl.pixel) begin
                bus.row_out <= row_cnt;
                bus.col_out <= col_cnt;
            end
            bus.win_valid_out <= ctrl.win_valid;
            bus.sof_out       <= ctrl.sof;
            bus.eol_out       <= ctrl.line_end;
            bus.eof_out       <= ctrl.eof;
            bus.flush_out     <= (state == ST_FLUSH);
            bus.busy_out      <= (next_state != ST_IDLE);
        end
    end

    assign bus.lb_wr_sel_out = lb_sel;
    assign bus.frame_cnt_out = frame_cnt;
    assign bus.err_out       = err;

endmodule

// File: tb/tb_sgm_frame_sequencer.sv
// Directed testbench for sgm_frame_sequencer on an 8x4 frame, 3x3 window,
// 4-cycle drain.
module tb_sgm_frame_sequencer;

    localparam int IMG_W        = 8;
    localparam int IMG_H        = 4;
    localparam int WIN_H        = 3;
    localparam int WIN_W        = 3;
    localparam int FLUSH_CYCLES = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sgm_frame_sequencer_if bus ();

    sgm_frame_sequencer #(
        .IMG_W        (IMG_W),
        .IMG_H        (IMG_H),
        .WIN_H        (WIN_H),
        .WIN_W        (WIN_W),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_sof, n_de, n_eol, n_eof, n_flush, n_win;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.sof_out === 1'b1)       n_sof++;
        if (bus.de_out === 1'b1)        n_de++;
        if (bus.eol_out === 1'b1)       n_eol++;
        if (bus.eof_out === 1'b1)       n_eof++;
        if (bus.flush_out === 1'b1)     n_flush++;
        if (bus.win_valid_out === 1'b1) n_win++;
    endtask

    task automatic clear_counts();
        n_sof = 0; n_de = 0; n_eol = 0; n_eof = 0; n_flush = 0; n_win = 0;
    endtask

    task automatic send_line(input int row, input int npix, input bit last, input bit exp_err);
        for (int c = 0; c < npix; c++) begin
            bus.de_in = 1'b1;
            tick();
            check("de_out", bus.de_out, 1);
            check("row_out", bus.row_out, row);
            check("col_out", bus.col_out, c);
            check("win_valid", bus.win_valid_out, (row >= WIN_H - 1) && (c >= WIN_W - 1));
        end
        bus.de_in = 1'b0;
        tick();
        check("eol_out", bus.eol_out, 1);
        check("eof_out", bus.eof_out, last);
        check("de_out_gap", bus.de_out, 0);
        check("lb_wr_sel", bus.lb_wr_sel_out, (row + 1) % (WIN_H - 1));
        check("err_at_eol", bus.err_out, exp_err);
        if (!last) begin
            bus.h_sync_in = 1'b1;
            tick();
            check("eol_single", bus.eol_out, 0);
            bus.h_sync_in = 1'b0;
            tick();
        end
    endtask

    task automatic vsync_pulse(input bit exp_sof);
        bus.v_sync_in = 1'b1;
        tick();
        check("sof_out", bus.sof_out, exp_sof);
        bus.v_sync_in = 1'b0;
        tick();
        check("sof_single", bus.sof_out, 0);
    endtask

    task automatic drain(input int exp_frames);
        for (int i = 0; i < FLUSH_CYCLES; i++) begin
            tick();
            check("flush_out", bus.flush_out, 1);
            if (i == 0) check("eof_single", bus.eof_out, 0);
        end
        check("frame_cnt_hold", bus.frame_cnt_out, exp_frames - 1);
        tick();
        check("flush_end", bus.flush_out, 0);
        check("frame_cnt", bus.frame_cnt_out, exp_frames);
    endtask

    task automatic full_frame(input int exp_frames);
        clear_counts();
        vsync_pulse(1'b1);
        check("err_after_sof", bus.err_out, 0);
        check("lb_after_sof", bus.lb_wr_sel_out, 0);
        for (int r = 0; r < IMG_H; r++) send_line(r, IMG_W, r == IMG_H - 1, 1'b0);
        drain(exp_frames);
        check("n_sof", n_sof, 1);
        check("n_de", n_de, IMG_W * IMG_H);
        check("n_eol", n_eol, IMG_H);
        check("n_eof", n_eof, 1);
        check("n_flush", n_flush, FLUSH_CYCLES);
        check("n_win", n_win, 12);
        check("err_nominal", bus.err_out, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_de_out"},    bus.de_out, 0);
        check({tag, "_row_out"},   bus.row_out, 0);
        check({tag, "_col_out"},   bus.col_out, 0);
        check({tag, "_win_valid"}, bus.win_valid_out, 0);
        check({tag, "_lb_sel"},    bus.lb_wr_sel_out, 0);
        check({tag, "_sof"},       bus.sof_out, 0);
        check({tag, "_eol"},       bus.eol_out, 0);
        check({tag, "_eof"},       bus.eof_out, 0);
        check({tag, "_flush"},     bus.flush_out, 0);
        check({tag, "_busy"},      bus.busy_out, 0);
        check({tag, "_frame_cnt"}, bus.frame_cnt_out, 0);
        check({tag, "_err"},       bus.err_out, 0);
    endtask

    initial begin
        // Reset state.
        rst           = 1'b1;
        bus.de_in     = 1'b0;
        bus.h_sync_in = 1'b0;
        bus.v_sync_in = 1'b0;
        bus.enable_in = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check("idle_busy", bus.busy_out, 0);

        // Not armed: vsync is ignored.
        vsync_pulse(1'b0);
        check("idle_still", bus.busy_out, 0);

        // Arm and run a nominal frame.
        bus.enable_in = 1'b1;
        tick();
        check("armed_busy", bus.busy_out, 1);
        full_frame(1);
        check("rearmed_busy", bus.busy_out, 1);

        // Short line on row 1: error from that eol, frame still completes.
        clear_counts();
        vsync_pulse(1'b1);
        check("short_err_pre", bus.err_out, 0);
        send_line(0, IMG_W, 1'b0, 1'b0);
        send_line(1, IMG_W - 1, 1'b0, 1'b1);
        send_line(2, IMG_W, 1'b0, 1'b1);
        send_line(3, IMG_W, 1'b1, 1'b1);
        drain(2);
        check("short_err_sticky", bus.err_out, 1);

        // Next sof clears the error; vsync after two lines truncates the frame.
        vsync_pulse(1'b1);
        check("err_cleared_sof", bus.err_out, 0);
        send_line(0, IMG_W, 1'b0, 1'b0);
        send_line(1, IMG_W, 1'b0, 1'b0);
        bus.v_sync_in = 1'b1;
        tick();
        check("trunc_sof", bus.sof_out, 1);
        check("trunc_err", bus.err_out, 1);
        check("trunc_lb", bus.lb_wr_sel_out, 0);
        check("trunc_frame_cnt", bus.frame_cnt_out, 2);
        check("trunc_busy", bus.busy_out, 1);
        bus.v_sync_in = 1'b0;
        tick();
        for (int r = 0; r < IMG_H; r++) send_line(r, IMG_W, r == IMG_H - 1, 1'b1);

        // Disarm during drain: back to IDLE, later vsync gives no sof.
        bus.enable_in = 1'b0;
        drain(3);
        check("disarm_busy", bus.busy_out, 0);
        check("disarm_err", bus.err_out, 1);
        vsync_pulse(1'b0);
        check("disarm_idle", bus.busy_out, 0);
        check("disarm_frame_cnt", bus.frame_cnt_out, 3);

        // Mid-frame reset during line 2.
        bus.enable_in = 1'b1;
        tick();
        vsync_pulse(1'b1);
        send_line(0, IMG_W, 1'b0, 1'b0);
        send_line(1, IMG_W, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            bus.de_in = 1'b1;
            tick();
        end
        check("pre_reset_de", bus.de_out, 1);
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst       = 1'b0;
        bus.de_in = 1'b0;
        tick();
        check("post_reset_busy", bus.busy_out, 1);
        full_frame(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
